// File: rtl/audioport_pkg.sv
// Shared audio-port definitions: default sample width and the I2S transmitter states.
package audioport_pkg;

  localparam int unsigned AUDIO_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    STOP
  } i2s_state_t;

endpackage

// File: rtl/i2s_unit.sv
// I2S transmitter in the mclk domain. Buffers the sample pair delivered with tick_in,
// requests the next pair with a one-cycle req_out at each frame start, and serialises
// left then right channel MSB first with the standard one-bit ws lead.
module i2s_unit
  import audioport_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AUDIO_WIDTH,
  parameter int unsigned SCK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play_in,
  input  logic                  tick_in,
  input  logic [DATA_WIDTH-1:0] audio0_in,
  input  logic [DATA_WIDTH-1:0] audio1_in,
  output logic                  req_out,
  output logic                  sck_out,
  output logic                  ws_out,
  output logic                  sdo_out
);

  localparam int unsigned FrameBits = 2 * DATA_WIDTH;
  localparam int unsigned DivW      = $clog2(SCK_DIV);
  localparam int unsigned BitW      = $clog2(FrameBits);

  localparam logic [DivW-1:0] DivLast = DivW'(SCK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(SCK_DIV / 2);
  localparam logic [BitW-1:0] BitLast = BitW'(FrameBits - 1);
  localparam logic [BitW-1:0] WsFirst = BitW'(DATA_WIDTH - 1);
  localparam logic [BitW-1:0] WsLast  = BitW'(FrameBits - 2);

  i2s_state_t             state_q, state_d;
  logic [DivW-1:0]        div_ctr_q, div_ctr_d;
  logic [BitW-1:0]        bit_ctr_q, bit_ctr_d;
  logic [FrameBits-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0]  buf1_q, buf1_d;
  logic                   req_q, req_d;

  logic div_wrap;
  logic frame_wrap;

  assign div_wrap   = (div_ctr_q == DivLast);
  assign frame_wrap = div_wrap && (bit_ctr_q == BitLast);

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_ctr_q <= '0;
      bit_ctr_q <= '0;
      shift_q   <= '0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_ctr_q <= div_ctr_d;
      bit_ctr_q <= bit_ctr_d;
      shift_q   <= shift_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      req_q     <= req_d;
    end
  end

  // Next-state logic: FSM, sck divider, bit counter, shift register and input buffer.
  always_comb begin
    state_d   = state_q;
    div_ctr_d = div_ctr_q;
    bit_ctr_d = bit_ctr_q;
    shift_d   = shift_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    req_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        div_ctr_d = '0;
        bit_ctr_d = '0;
        if (play_in) begin
          state_d = PLAY;
          shift_d = {buf0_q, buf1_q};
          req_d   = 1'b1;
        end
      end

      PLAY, STOP: begin
        div_ctr_d = div_wrap ? '0 : div_ctr_q + DivW'(1);
        if (div_wrap) begin
          bit_ctr_d = frame_wrap ? '0 : bit_ctr_q + BitW'(1);
          shift_d   = {shift_q[FrameBits-2:0], 1'b0};
        end
        // play_in only decides the mode; a STOP frame runs to its end like a PLAY frame.
        state_d = play_in ? PLAY : STOP;
        if (frame_wrap) begin
          if (state_q == PLAY || play_in) begin
            shift_d = {buf0_q, buf1_q};
            req_d   = 1'b1;
          end else begin
            state_d = IDLE;
            shift_d = '0;
            buf0_d  = '0;
            buf1_d  = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // A tick always wins, including over the clear on entry to IDLE.
    if (tick_in) begin
      buf0_d = audio0_in;
      buf1_d = audio1_in;
    end
  end

  // Output decode from registers only.
  always_comb begin
    req_out = req_q;
    sck_out = (state_q != IDLE) && (div_ctr_q >= DivHalf);
    ws_out  = (bit_ctr_q >= WsFirst) && (bit_ctr_q <= WsLast);
    sdo_out = shift_q[FrameBits-1];
  end

endmodule

// File: tb/tb_i2s_unit.sv
// Scoreboard bench for i2s_unit: stimulus pushes expected frame contents, a monitor
// reassembles frames from sdo on sck rising edges and checks ws, latency and req timing.
module tb_i2s_unit;

  localparam int unsigned DW     = 24;
  localparam int unsigned DIV    = 4;
  localparam int unsigned FRAME  = 2 * DW;
  localparam int unsigned PERIOD = FRAME * DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic          play_in;
  logic          tick_in;
  logic [DW-1:0] audio0_in;
  logic [DW-1:0] audio1_in;
  logic          req_out;
  logic          sck_out;
  logic          ws_out;
  logic          sdo_out;

  i2s_unit #(
    .DATA_WIDTH(DW),
    .SCK_DIV   (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .play_in  (play_in),
    .tick_in  (tick_in),
    .audio0_in(audio0_in),
    .audio1_in(audio1_in),
    .req_out  (req_out),
    .sck_out  (sck_out),
    .ws_out   (ws_out),
    .sdo_out  (sdo_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] buf_model;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  int              cyc = 0;
  int              idx = FRAME;
  int              last_req_cyc = 0;
  int              ws_rise_cyc = 0;
  int              fall_cyc = 0;
  int              req_cnt = 0;
  bit              have_req = 0;
  logic            sck_prev = 0, ws_prev = 0, req_prev = 0;
  logic [2*DW-1:0] frame_bits = '0;

  // Sample on the falling clk edge; stimulus changes 1 time unit later.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      idx      = FRAME;
      have_req = 0;
      sck_prev = 0;
      ws_prev  = 0;
      req_prev = 0;
      exp_q.delete();
    end else begin
      if (req_out) begin
        chk("req_width", 64'(req_prev), 64'd0);
        if (have_req) chk("req_period", 64'(cyc - last_req_cyc), 64'(PERIOD));
        chk("frame_complete_at_req", 64'(idx), 64'(FRAME));
        have_req     = 1;
        last_req_cyc = cyc;
        req_cnt++;
        idx = 0;
      end
      if (ws_out && !ws_prev) ws_rise_cyc = cyc;
      if (!sck_out && sck_prev) fall_cyc = cyc;
      if (sck_out && !sck_prev) begin
        if (idx >= int'(FRAME)) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_capture: got capture %0d, expected none past %0d", idx, FRAME);
        end else begin
          if (idx == 0) chk("first_capture_latency", 64'(cyc - last_req_cyc), 64'd2);
          // ws leads the right MSB slot (the sck fall that presents it) by one sck period.
          if (idx == int'(DW)) chk("ws_lead", 64'(fall_cyc - ws_rise_cyc), 64'(DIV));
          chk("ws", 64'(ws_out), 64'(idx >= int'(DW - 1) && idx <= int'(FRAME - 2)));
          frame_bits[FRAME-1-idx] = sdo_out;
          idx++;
          if (idx == int'(FRAME)) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL frame_unexpected: got %0h, expected no frame", frame_bits);
            end else begin
              chk("frame_data", 64'(frame_bits), 64'(exp_q.pop_front()));
            end
          end
        end
      end
      sck_prev = sck_out;
      ws_prev  = ws_out;
      req_prev = req_out;
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    do begin
      nxt();
      tick_in = 1'b0;
      n++;
    end while (req_out !== 1'b1 && n < 2 * PERIOD);
    chk("req_seen", 64'(req_out), 64'd1);
  endtask

  // Runs the frame that started at the req just seen (cycle 0).
  // tick_at: 1..191 tick on that cycle, -1 no tick (repeat), -2 no tick and no next frame.
  task automatic run_frame(input int tick_at, input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                           input int stop_at, input int resume_at, input bit more);
    for (int k = 1; k < int'(PERIOD); k++) begin
      nxt();
      tick_in = 1'b0;
      // A tick on the wrap cycle lands after the reload: the next frame keeps the old pair.
      if (more && k == 1 && (tick_at == -1 || tick_at == int'(PERIOD) - 1)) exp_q.push_back(buf_model);
      if (k == tick_at) begin
        tick_in   = 1'b1;
        audio0_in = a0;
        audio1_in = a1;
        buf_model = {a0, a1};
        if (more && tick_at != int'(PERIOD) - 1) exp_q.push_back(buf_model);
      end
      if (k == stop_at) play_in = 1'b0;
      if (k == resume_at) play_in = 1'b1;
    end
    if (more) wait_req();
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_req"}, 64'(req_out), 64'd0);
    chk({name, "_sck"}, 64'(sck_out), 64'd0);
    chk({name, "_ws"},  64'(ws_out),  64'd0);
    chk({name, "_sdo"}, 64'(sdo_out), 64'd0);
  endtask

  initial begin
    logic bad;
    int   reqs_before;
    rst       = 1'b1;
    play_in   = 1'b0;
    tick_in   = 1'b0;
    audio0_in = '0;
    audio1_in = '0;
    repeat (3) nxt();
    chk_outputs_zero("reset");
    rst = 1'b0;
    nxt();

    // Reset in the middle of a frame.
    tick_in = 1'b1; audio0_in = 24'h111111; audio1_in = 24'h222222;
    exp_q.push_back({24'h111111, 24'h222222});
    nxt();
    tick_in = 1'b0;
    play_in = 1'b1;
    wait_req();
    repeat (20 * DIV) nxt();
    rst     = 1'b1;
    play_in = 1'b0;
    nxt();
    rst = 1'b0;
    chk_outputs_zero("mid_frame_reset");
    bad = 1'b0;
    repeat (40) begin
      nxt();
      if (req_out || sck_out || ws_out || sdo_out) bad = 1'b1;
    end
    chk("idle_after_reset", 64'(bad), 64'd0);

    // Start with a fresh pair.
    tick_in = 1'b1; audio0_in = 24'hA5A5A5; audio1_in = 24'h5A5A5A;
    buf_model = {24'hA5A5A5, 24'h5A5A5A};
    exp_q.push_back(buf_model);
    nxt();
    tick_in = 1'b0;
    play_in = 1'b1;
    wait_req();

    // Steady state, a missing tick, then a tick on the frame-wrap cycle.
    run_frame(3, 24'h123456, 24'hFEDCBA, -1, -1, 1'b1);
    run_frame(3, 24'h0F0F0F, 24'hF0F0F0, -1, -1, 1'b1);
    run_frame(-1, 24'h000000, 24'h000000, -1, -1, 1'b1);
    run_frame(3, 24'h000001, 24'hFFFFFE, -1, -1, 1'b1);
    run_frame(int'(PERIOD) - 1, 24'h800000, 24'h7FFFFF, -1, -1, 1'b1);
    // Drop and restore play_in within one frame: stream must stay continuous.
    run_frame(-1, 24'h000000, 24'h000000, 10 * DIV, 25 * DIV, 1'b1);
    // Stop at bit 10: frame completes, then silence.
    reqs_before = req_cnt;
    run_frame(-2, 24'h000000, 24'h000000, 10 * DIV, -1, 1'b0);
    nxt();
    chk_outputs_zero("after_stop");
    bad = 1'b0;
    repeat (100) begin
      nxt();
      if (req_out || sck_out || ws_out || sdo_out) bad = 1'b1;
    end
    chk("idle_after_stop", 64'(bad), 64'd0);
    chk("no_req_after_stop", 64'(req_cnt - reqs_before), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
